// File: rtl/bike_pkg.sv
// Shared constants, widths and FSM state type for the bicycle computer front end.
package bike_pkg;

  localparam int CLK_HZ     = 2048;
  localparam int SPEED_K    = CLK_HZ * 36;
  localparam int SPEED_MAX  = 999;
  localparam int PERIOD_W   = 16;
  localparam int SPEED_W    = 10;
  localparam int CIRC_W     = 8;
  localparam int DIVIDEND_W = 25;
  localparam int DIVISOR_W  = 23;

  typedef enum logic [1:0] {
    IDLE_FIRST,
    MEASURE,
    DIVIDE
  } meter_state_t;

  function automatic logic [SPEED_W-1:0] clamp_speed(input logic [DIVIDEND_W-1:0] q);
    if (q > DIVIDEND_W'(SPEED_MAX)) return SPEED_W'(SPEED_MAX);
    return q[SPEED_W-1:0];
  endfunction

endpackage

// File: rtl/restoring_divider.sv
// Restoring unsigned divider: one quotient bit per cycle, DVD_W-cycle latency.
module restoring_divider #(
  parameter int DVD_W = 25,
  parameter int DVS_W = 23
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [DVD_W-1:0] quotient
);

  localparam int CNT_W = $clog2(DVD_W + 1);

  logic [DVS_W-1:0] rem;
  logic [DVS_W-1:0] dvs;
  logic [CNT_W-1:0] cnt;
  logic [DVS_W:0]   shifted;
  logic [DVS_W-1:0] diff;
  logic             fits;

  // The quotient register doubles as the dividend shifter.
  always_comb begin
    shifted = {rem, quotient[DVD_W-1]};
    fits    = shifted >= {1'b0, dvs};
    diff    = shifted[DVS_W-1:0] - dvs;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rem      <= '0;
      dvs      <= '0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      quotient <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        quotient <= dividend;
        rem      <= '0;
        dvs      <= divisor;
        cnt      <= CNT_W'(DVD_W);
        busy     <= 1'b1;
      end else if (busy) begin
        if (fits) begin
          rem      <= diff;
          quotient <= {quotient[DVD_W-2:0], 1'b1};
        end else begin
          rem      <= shifted[DVS_W-1:0];
          quotient <= {quotient[DVD_W-2:0], 1'b0};
        end
        cnt <= cnt - 1'b1;
        if (cnt == CNT_W'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/reed_speed_meter.sv
// Reed-switch conditioning, revolution period measurement and speed computation
// in 0.1 km/h units with standstill detection.
module reed_speed_meter #(
  parameter int CLK_HZ  = bike_pkg::CLK_HZ,
  parameter int LOCKOUT = 40,
  parameter int TIMEOUT = 8192
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         reed,
  input  logic [bike_pkg::CIRC_W-1:0]  circ,
  output logic                         rev_pulse,
  output logic [bike_pkg::SPEED_W-1:0] speed_x10,
  output logic                         speed_valid,
  output logic                         stopped
);

  import bike_pkg::*;

  localparam int LK_W    = $clog2(LOCKOUT + 1);
  localparam int SPEED_C = CLK_HZ * 36;

  logic [2:0]            sync;
  logic [LK_W-1:0]       lockout;
  logic [PERIOD_W-1:0]   period_cnt;
  meter_state_t          state;

  logic                  rise;
  logic                  accept;
  logic                  timeout_hit;
  logic                  div_start;
  logic                  div_busy;
  logic                  div_done;
  logic [DIVIDEND_W-1:0] dividend;
  logic [DIVISOR_W-1:0]  divisor;
  logic [DIVIDEND_W-1:0] quotient;

  // NOTE: every signal in a combinational block is assigned on every path, so no latch can form.
  always_comb begin
    rise        = sync[1] & ~sync[2];
    accept      = rise && (lockout == '0);
    timeout_hit = (state != IDLE_FIRST) && !accept &&
                  (period_cnt == PERIOD_W'(TIMEOUT - 1));
    div_start   = accept && (state == MEASURE) && !div_busy;
    dividend    = DIVIDEND_W'(circ) * DIVIDEND_W'(SPEED_C);
    divisor     = DIVISOR_W'(period_cnt) * DIVISOR_W'(100);
  end

  assign rev_pulse = accept;

  // sync[1:0] is the metastability synchronizer; sync[2] holds the previous sample for edge detect.
  // NOTE: non-blocking assignments make every flop sample pre-edge values, so the chain shifts one stage per clock.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync       <= '0;
      lockout    <= '0;
      period_cnt <= '0;
    end else begin
      sync <= {sync[1:0], reed};
      if (accept)               lockout <= LK_W'(LOCKOUT);
      else if (lockout != '0)   lockout <= lockout - 1'b1;
      if (accept)                                   period_cnt <= PERIOD_W'(1);
      else if (period_cnt != PERIOD_W'(TIMEOUT))    period_cnt <= period_cnt + 1'b1;
    end
  end

  restoring_divider #(
    .DVD_W(DIVIDEND_W),
    .DVS_W(DIVISOR_W)
  ) u_div (
    .clock    (clock),
    .reset    (reset),
    .start    (div_start),
    .dividend (dividend),
    .divisor  (divisor),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (quotient)
  );

  // Timeout overrides everything; a division still in flight finishes unobserved.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE_FIRST;
      speed_x10   <= '0;
      speed_valid <= 1'b0;
      stopped     <= 1'b1;
    end else begin
      speed_valid <= 1'b0;
      if (timeout_hit) begin
        state       <= IDLE_FIRST;
        speed_x10   <= '0;
        speed_valid <= 1'b1;
        stopped     <= 1'b1;
      end else begin
        case (state)
          IDLE_FIRST: if (accept) state <= MEASURE;
          MEASURE:    if (div_start) state <= DIVIDE;
          DIVIDE: begin
            if (div_done) begin
              state       <= MEASURE;
              speed_x10   <= clamp_speed(quotient);
              speed_valid <= 1'b1;
              stopped     <= 1'b0;
            end
          end
          default:    state <= IDLE_FIRST;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_reed_speed_meter.sv
// Scoreboard bench for reed_speed_meter: directed reed patterns, expected speeds queued at stimulus time.
module tb_reed_speed_meter;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       reed  = 1'b0;
  logic [7:0] circ  = 8'd0;
  logic       rev_pulse;
  logic [9:0] speed_x10;
  logic       speed_valid;
  logic       stopped;

  reed_speed_meter dut (
    .clock       (clock),
    .reset       (reset),
    .reed        (reed),
    .circ        (circ),
    .rev_pulse   (rev_pulse),
    .speed_x10   (speed_x10),
    .speed_valid (speed_valid),
    .stopped     (stopped)
  );

  always #5 clock = ~clock;

  typedef struct {
    int speed;
    int stp;
    bit lat;
  } exp_t;

  exp_t exp_q[$];
  int   cyc       = 0;
  int   n_checks  = 0;
  int   n_err     = 0;
  int   rev_count = 0;
  int   last_rev  = 0;
  int   spurious  = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic push(input int speed, input int stp, input bit lat);
    exp_t e;
    e.speed = speed;
    e.stp   = stp;
    e.lat   = lat;
    exp_q.push_back(e);
  endtask

  // Called at a negedge; the next rising edge of reed comes exactly gap cycles later.
  task automatic reed_edge(input int gap);
    reed = 1'b1;
    repeat (2) @(negedge clock);
    reed = 1'b0;
    repeat (gap - 2) @(negedge clock);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock);
      if (rev_pulse === 1'b1) begin
        rev_count++;
        last_rev = cyc;
      end
      if (speed_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          spurious++;
        end else begin
          e = exp_q.pop_front();
          check("speed_x10", int'(speed_x10), e.speed);
          check("stopped_at_valid", int'(stopped), e.stp);
          if (e.lat) check("result_latency", cyc - last_rev, 27);
        end
      end
    end
  end

  initial begin : stimulus
    int rc;
    int k;

    repeat (3) @(negedge clock);
    check("rst_stopped", int'(stopped), 1);
    check("rst_speed", int'(speed_x10), 0);
    check("rst_rev_pulse", int'(rev_pulse), 0);
    check("rst_speed_valid", int'(speed_valid), 0);
    reset = 1'b1;
    repeat (50) @(negedge clock);
    check("idle_rev_count", rev_count, 0);
    check("idle_stopped", int'(stopped), 1);

    // 2048-tick period then 512 and 100 (clamped)
    circ = 8'd220;
    reed_edge(2048);
    check("first_edge_still_stopped", int'(stopped), 1);
    push(79, 0, 1);
    reed_edge(512);
    push(316, 0, 1);
    reed_edge(512);
    push(316, 0, 1);
    reed_edge(100);
    push(999, 0, 1);
    reed_edge(100);
    check("speed_after_clamp", int'(speed_x10), 999);

    // Bounce: edges at +5 and +20 ignored, +41 accepted with P = 41
    circ = 8'd10;
    push(73, 0, 1);
    reed_edge(5);
    reed_edge(15);
    reed_edge(21);
    push(179, 0, 1);
    reed_edge(50);
    check("bounce_rev_count", rev_count, 7);
    check("bounce_queue_empty", exp_q.size(), 0);
    check("bounce_stopped", int'(stopped), 0);

    // Standstill timeout
    push(0, 1, 0);
    repeat (8192) @(negedge clock);
    check("timeout_stopped", int'(stopped), 1);
    check("timeout_speed", int'(speed_x10), 0);
    check("timeout_queue_empty", exp_q.size(), 0);

    // First edge after timeout gives no speed; the next one does
    reed_edge(300);
    check("restart_first_stopped", int'(stopped), 1);
    push(24, 0, 1);
    reed_edge(100);
    check("restart_rev_count", rev_count, 9);
    check("restart_stopped", int'(stopped), 0);
    check("restart_queue_empty", exp_q.size(), 0);

    // Reset during a division
    rc = rev_count;
    k  = 0;
    reed = 1'b1;
    while (rev_count == rc && k < 10) begin
      @(negedge clock);
      k++;
    end
    check("abort_rev_seen", rev_count, rc + 1);
    reed = 1'b0;
    repeat (10) @(posedge clock);
    #2 reset = 1'b0;
    #1;
    check("abort_rst_speed", int'(speed_x10), 0);
    check("abort_rst_stopped", int'(stopped), 1);
    check("abort_rst_valid", int'(speed_valid), 0);
    check("abort_rst_rev_pulse", int'(rev_pulse), 0);
    repeat (5) @(negedge clock);
    reset = 1'b1;
    repeat (60) @(negedge clock);
    check("abort_no_result_stopped", int'(stopped), 1);
    check("final_rev_count", rev_count, 10);
    check("final_queue_empty", exp_q.size(), 0);
    check("spurious_speed_valid", spurious, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/reed_speed_meter.md
Name: reed_speed_meter

Overview:
- Front-end measurement stage of the bicycle computer, directly upstream of the display/mode logic.
- Conditions the raw reed-switch input, emits one pulse per wheel revolution for the distance counter, and measures the revolution period in clock ticks.
- Converts the period plus the wheel circumference `circ` into current speed in 0.1 km/h units, with standstill detection.

Parameters:
- CLK_HZ, 2048, clock frequency in Hz; fixes the speed constant.
- LOCKOUT, 40, ticks after an accepted reed edge during which further edges are ignored (debounce); must be ≥ 32.
- TIMEOUT, 8192, ticks without an accepted edge before the wheel counts as stopped; ≤ 65535.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- reed  in  1  raw reed switch, asynchronous to clock; high for ≥ 2 clock periods per pass.
- circ  in  8  wheel circumference in cm; sampled at divider start.
- rev_pulse  out  1  one-cycle pulse per accepted revolution.
- speed_x10  out  10  current speed in 0.1 km/h, 0..999.
- speed_valid  out  1  one-cycle pulse when speed_x10 is updated.
- stopped  out  1  high while no valid period is available.

Behaviour:
- Reset, asynchronous and active-low: all outputs are 0 except stopped = 1. Synchronizer, lockout counter, period counter and divider are cleared. The `first` flag is set.
- Reset asserted mid-division aborts the division with no speed_valid pulse.
- Input conditioning:
  - 2-flop synchronizer on reed, then rising-edge detect.
  - An edge is accepted only when the lockout counter is 0.
  - On acceptance the lockout counter loads LOCKOUT and decrements to 0.
  - Edges seen while the counter is nonzero are discarded.
- Accepted edge in cycle E:
  - rev_pulse = 1 in cycle E.
  - The period counter value is captured as P, and the counter restarts at 1 in E+1.
- Period counter:
  - 16 bits, incremented every cycle, saturates at TIMEOUT.
  - On reaching TIMEOUT: speed_x10 ← 0, stopped ← 1, first ← 1, and one speed_valid pulse is issued.
  - Saturation occurs once per stop episode.
- The first accepted edge after reset or timeout only restarts the counter and clears first; no division is performed.
- Subsequent accepted edges start a division in E+1 using:
  - dividend = circ × (CLK_HZ × 36), 25 bits (73728 × 255 max).
  - divisor = P × 100, 23 bits.
- Division: restoring, 1 quotient bit per cycle, 25 cycles, truncating.
- Result, exactly 27 cycles after rev_pulse:
  - quotient > 999 → clamp to 999.
  - speed_x10 ← quotient, speed_valid = 1 for one cycle, stopped ← 0.
- circ = 0: result is 0, and stopped still clears.
- Edge accepted while the divider is busy: rev_pulse is still issued and the counter restarts; no new division starts, and the in-flight result is kept. This cannot occur when LOCKOUT ≥ 32; it is defined for robustness only.
- Timeout while the divider is busy: the division is aborted, and the timeout result (speed 0, stopped) wins.
- FSM states:
  - IDLE_FIRST: awaits the first edge.
  - MEASURE: counting.
  - DIVIDE: division in progress, with the period counter still running.
  - Transitions: IDLE_FIRST → MEASURE on an edge. MEASURE → DIVIDE on an edge. DIVIDE → MEASURE on done. MEASURE or DIVIDE → IDLE_FIRST on timeout.

Decomposition:
- Shared package bike_pkg holds:
  - CLK_HZ.
  - SPEED_K = CLK_HZ × 36.
  - SPEED_MAX = 999.
  - Width constants: PERIOD_W = 16, SPEED_W = 10, CIRC_W = 8.
  - The FSM state typedef.
- Sub-module restoring_divider, parameterised on widths.
  - Ports: clock, reset, start, dividend, divisor, busy, done, quotient.
  - Fixed 25-cycle latency.
  - Division by 0 returns all-ones, which then clamps to 999.

Test Plan:
- Reset low mid-operation, then released → stopped = 1, speed_x10 = 0, no rev_pulse or speed_valid until a reed edge.
- circ = 220, two reed pulses 2048 ticks apart → rev_pulse on each; speed_valid 27 cycles after the second; speed_x10 = 79.
- circ = 220, steady reed period 512 ticks → speed_x10 = 316 after each revolution. Period 100 ticks → clamped to 999.
- Reed bounce: extra rising edges 5 and 20 ticks after an accepted edge → ignored (no rev_pulse). An edge at tick 41 is accepted with P = 41.
- After a valid speed, no reed for 8192 ticks → speed_x10 = 0, stopped = 1, a single speed_valid. The next single edge gives no speed; the following edge does.
- Reset asserted 10 cycles into a division → no speed_valid; outputs at reset values immediately (asynchronous).
